select_bus_dist: RTL and testbench

- Inverse of the 4:1 bus selector: one n-bit input bus is routed by sel to one of four registered output channels.
- Each output channel has a one-entry holding buffer and its own valid/ready handshake.
- Feeds four downstream consumers from one shared producer. Input side is valid/ready, gated by enable.

---
 rtl/select_bus_dist_pkg.sv | 15 +
 rtl/dist_chan.sv | 71 +++++++
 rtl/select_bus_dist.sv | 60 ++++++
 tb/tb_select_bus_dist.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/select_bus_dist_pkg.sv
// Shared constants and channel state encoding for the select_bus_dist block.
// Optional per-channel transfer counters are enabled with SELECT_BUS_DIST_CNT_EN.
package select_bus_dist_pkg;

  localparam int unsigned NCH   = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/dist_chan.sv
// One output channel: a one-entry holding buffer with valid/ready drain.
// With SELECT_BUS_DIST_CNT_EN defined, also keeps a saturating accept counter.
module dist_chan
  import select_bus_dist_pkg::*;
#(
  parameter int unsigned n = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [n:1]       din,
  output logic [n:1]       dout,
  output logic             valid,
  input  logic             ready,
`ifdef SELECT_BUS_DIST_CNT_EN
  output logic [CNT_W-1:0] cnt,
`endif
  output logic             full
);

  ch_state_e  state_q, state_d;
  logic [n:1] data_q, data_d;

  // A load while full implies ready was high, so replacing the word loses nothing.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = CH_FULL;
      data_d  = din;
    end else if ((state_q == CH_FULL) && ready) begin
      state_d = CH_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CH_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign dout  = data_q;
  assign valid = (state_q == CH_FULL);
  assign full  = (state_q == CH_FULL);

`ifdef SELECT_BUS_DIST_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
`endif

endmodule

// File: rtl/select_bus_dist.sv
// Routes one valid/ready input bus to one of four buffered output channels by sel.
// Define SELECT_BUS_DIST_CNT_EN to expose per-channel transfer counters on xfer_cnt.
module select_bus_dist
  import select_bus_dist_pkg::*;
#(
  parameter int unsigned n = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] sel,
  input  logic [n:1]       bus_in,
  output logic [n:1]       bus_out0,
  output logic [n:1]       bus_out1,
  output logic [n:1]       bus_out2,
  output logic [n:1]       bus_out3,
  output logic [NCH-1:0]   out_valid,
`ifdef SELECT_BUS_DIST_CNT_EN
  output logic [31:0]      xfer_cnt,
`endif
  input  logic [NCH-1:0]   out_ready
);

  logic [NCH-1:0] full;
  logic [NCH-1:0] load;
  logic [n:1]     dout [NCH];
  logic           accept;

  // in_ready never looks at in_valid, so the producer may hold in_valid on it.
  assign in_ready = enable & (~full[sel] | out_ready[sel]);
  assign accept   = in_valid & in_ready;

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    assign load[k] = accept & (sel == SEL_W'(k));

    dist_chan #(
      .n(n)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .load (load[k]),
      .din  (bus_in),
      .dout (dout[k]),
      .valid(out_valid[k]),
      .ready(out_ready[k]),
`ifdef SELECT_BUS_DIST_CNT_EN
      .cnt  (xfer_cnt[8*k+:8]),
`endif
      .full (full[k])
    );
  end

  assign bus_out0 = dout[0];
  assign bus_out1 = dout[1];
  assign bus_out2 = dout[2];
  assign bus_out3 = dout[3];

endmodule

// File: tb/tb_select_bus_dist.sv
// Directed plus randomized bench for select_bus_dist against a per-channel buffer model.
// Counter checks are active when SELECT_BUS_DIST_CNT_EN is defined.
module tb_select_bus_dist;

  logic        clk;
  logic        rst;
  logic        en;
  logic        iv;
  logic        in_ready;
  logic [1:0]  s;
  logic [16:1] din;
  logic [16:1] bo0, bo1, bo2, bo3;
  logic [3:0]  ov;
  logic [3:0]  ordy;
`ifdef SELECT_BUS_DIST_CNT_EN
  logic [31:0] xfer_cnt;
`endif

  select_bus_dist #(
    .n(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (en),
    .in_valid (iv),
    .in_ready (in_ready),
    .sel      (s),
    .bus_in   (din),
    .bus_out0 (bo0),
    .bus_out1 (bo1),
    .bus_out2 (bo2),
    .bus_out3 (bo3),
    .out_valid(ov),
`ifdef SELECT_BUS_DIST_CNT_EN
    .xfer_cnt (xfer_cnt),
`endif
    .out_ready(ordy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: what each consumer should currently see.
  logic        m_full [4];
  logic [16:1] m_data [4];
  logic [7:0]  m_cnt  [4];

  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:1] bus_of(input int k);
    case (k)
      0:       return bo0;
      1:       return bo1;
      2:       return bo2;
      default: return bo3;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_full[k] = 1'b0;
      m_data[k] = '0;
      m_cnt[k]  = '0;
    end
  endtask

  // Inputs are already set (after a negedge): check, clock once, advance the model.
  task automatic step();
    logic exp_rdy;
    logic acc;
    #1;
    exp_rdy = en && (!m_full[s] || ordy[s]);
    chk("in_ready", in_ready, exp_rdy);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("out_valid[%0d]", k), ov[k], m_full[k]);
      chk($sformatf("bus_out%0d", k), bus_of(k), m_data[k]);
    end
`ifdef SELECT_BUS_DIST_CNT_EN
    chk("xfer_cnt", xfer_cnt, {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]});
`endif
    acc = iv && exp_rdy;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (acc && (int'(s) == k)) begin
          m_full[k] = 1'b1;
          m_data[k] = din;
          if (m_cnt[k] != 8'hFF) m_cnt[k] = m_cnt[k] + 8'd1;
        end else if (m_full[k] && ordy[k]) begin
          m_full[k] = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] sel_v, input logic [16:1] d);
    iv  = 1'b1;
    s   = sel_v;
    din = d;
    step();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; iv = 1'b0; s = 2'd0; din = '0; ordy = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b0;

    // Reset state, then one word per channel on consecutive cycles.
    en = 1'b1; ordy = 4'hF;
    iv = 1'b0;
    step();
    send(2'd0, 16'hAAAA);
    send(2'd1, 16'hBBBB);
    send(2'd2, 16'hCCCC);
    send(2'd3, 16'hDDDD);
    iv = 1'b0;
    step();
    step();

    // Backpressure on channel 2, then release with a same-cycle refill.
    ordy = 4'b1011;
    send(2'd2, 16'hCCCC);
    send(2'd2, 16'hEEEE);
    send(2'd2, 16'hEEEE);
    ordy = 4'hF;
    send(2'd2, 16'hEEEE);
    iv = 1'b0;
    step();

    // Channel 1 stalled while channel 3 keeps accepting.
    ordy = 4'b1101;
    send(2'd1, 16'h7777);
    send(2'd3, 16'h1234);
    iv = 1'b0;
    step();
    ordy = 4'hF;
    step();

    // Enable low holds off the producer.
    en = 1'b0;
    for (int i = 0; i < 5; i++) send(2'd0, 16'h5555);
    en = 1'b1;
    send(2'd0, 16'h5555);
    iv = 1'b0;
    step();

    // Reset with every channel full and stalled.
    ordy = 4'h0;
    for (int k = 0; k < 4; k++) send(2'(k), 16'hF000 + 16'(k));
    iv = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    // Saturate channel 1's counter.
    ordy = 4'hF;
    for (int i = 0; i < 300; i++) send(2'd1, 16'(i));
    iv = 1'b0;
    step();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 7) != 0);
      iv   = $urandom_range(0, 3) != 0;
      s    = 2'($urandom_range(0, 3));
      din  = 16'($urandom);
      ordy = 4'($urandom);
      rst  = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0;
    iv  = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
